// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and defaults for the subtractor operand loader
package sub_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_operand_loader_if.sv
// rtl/sub_operand_loader_if.sv - byte input and operand-pair handshake bundle
interface sub_operand_loader_if
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             din_stb;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             op_ready;

    // Byte source and subtractor side
    modport master (
        output din, din_stb, op_ready,
        input  op_a, op_b, op_valid
    );

    // Operand loader side
    modport slave (
        input  din, din_stb, op_ready,
        output op_a, op_b, op_valid
    );

endinterface

// File: rtl/sub_load_timer.sv
// rtl/sub_load_timer.sv - loadable saturating idle counter with terminal-count flag
module sub_load_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    // Restart from zero on load, otherwise count up and stop at the last idle slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ena) begin
            if (load) begin
                count <= '0;
            end else if (inc && (count != LAST)) begin
                count <= count + 1'b1;
            end
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/sub_operand_loader.sv
// rtl/sub_operand_loader.sv - assembles operand A then B from the byte bus and issues the pair
module sub_operand_loader
    import sub_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clear,
    sub_operand_loader_if.slave  bus,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             tmr_load, tmr_inc, tmr_tc;

    sub_load_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .load  (tmr_load),
        .inc   (tmr_inc),
        .tc    (tmr_tc)
    );

    // Next-state and register updates; nothing moves while ena is low, and the
    // timeout pulse is a default-zero so it always falls after one cycle
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        overrun_d = overrun_q;
        timeout_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_inc   = 1'b0;
        if (ena) begin
            if (clear) begin
                state_d   = IDLE;
                overrun_d = 1'b0;
                tmr_load  = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.din_stb) begin
                            op_a_d   = bus.din;
                            tmr_load = 1'b1;
                            state_d  = GOT_A;
                        end
                    end
                    GOT_A: begin
                        if (bus.din_stb) begin
                            op_b_d  = bus.din;
                            state_d = ISSUE;
                        end else if (tmr_tc) begin
                            state_d   = IDLE;
                            timeout_d = 1'b1;
                            tmr_load  = 1'b1;
                        end else begin
                            tmr_inc = 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (bus.op_ready) begin
                            // A strobe on the handshake cycle starts the next pair at once
                            if (bus.din_stb) begin
                                op_a_d   = bus.din;
                                tmr_load = 1'b1;
                                state_d  = GOT_A;
                            end else begin
                                state_d = IDLE;
                            end
                        end else if (bus.din_stb) begin
                            overrun_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State, operand and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_valid = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_sub_operand_loader.sv
// tb/tb_sub_operand_loader.sv - randomized and directed checks of sub_operand_loader against a reference model
module tb_sub_operand_loader;

    localparam int W = 8;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic clear;
    logic busy;
    logic overrun;
    logic timeout;

    sub_operand_loader_if #(.WIDTH(W)) bus ();

    sub_operand_loader #(
        .WIDTH   (W),
        .TIMEOUT (T)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .clear   (clear),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what has been collected so far, in plain terms
    bit         m_have_a;
    bit         m_pair;
    logic [7:0] m_a;
    logic [7:0] m_b;
    bit         m_ovr;
    bit         m_to;
    int         m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have_a = 0;
        m_pair   = 0;
        m_a      = '0;
        m_b      = '0;
        m_ovr    = 0;
        m_to     = 0;
        m_idle   = 0;
    endtask

    task automatic check_all();
        check("op_a",     32'(bus.op_a),     32'(m_a));
        check("op_b",     32'(bus.op_b),     32'(m_b));
        check("op_valid", 32'(bus.op_valid), 32'(m_pair));
        check("busy",     32'(busy),         32'(m_have_a | m_pair));
        check("overrun",  32'(overrun),      32'(m_ovr));
        check("timeout",  32'(timeout),      32'(m_to));
    endtask

    task automatic model_update(input bit e, input bit s, input logic [7:0] d, input bit c, input bit r);
        m_to = 0;
        if (e) begin
            if (c) begin
                m_have_a = 0;
                m_pair   = 0;
                m_ovr    = 0;
                m_idle   = 0;
            end else if (m_pair) begin
                if (r) begin
                    m_pair = 0;
                    if (s) begin
                        m_a      = d;
                        m_have_a = 1;
                        m_idle   = 0;
                    end
                end else if (s) begin
                    m_ovr = 1;
                end
            end else if (m_have_a) begin
                if (s) begin
                    m_b      = d;
                    m_have_a = 0;
                    m_pair   = 1;
                end else if (m_idle == T - 1) begin
                    m_have_a = 0;
                    m_to     = 1;
                    m_idle   = 0;
                end else begin
                    m_idle++;
                end
            end else if (s) begin
                m_a      = d;
                m_have_a = 1;
                m_idle   = 0;
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input logic [7:0] d, input bit c, input bit r);
        ena          = e;
        bus.din_stb  = s;
        bus.din      = d;
        clear        = c;
        bus.op_ready = r;
        @(posedge clk);
        model_update(e, s, d, c, r);
        #1;
        check_all();
    endtask

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b0;
        clear        = 1'b0;
        bus.din      = '0;
        bus.din_stb  = 1'b0;
        bus.op_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Basic pair with ready already high
        step(1, 1, 8'h2A, 0, 1);
        step(1, 1, 8'h0F, 0, 1);
        check("t1_a", 32'(bus.op_a), 32'h2A);
        check("t1_b", 32'(bus.op_b), 32'h0F);
        check("t1_valid", 32'(bus.op_valid), 32'd1);
        step(1, 0, 8'h00, 0, 1);
        check("t1_idle", 32'(busy), 32'd0);

        // Stalled handshake, strobe during stall is dropped
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        repeat (5) step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        check("t2_ovr", 32'(overrun), 32'd1);
        check("t2_a", 32'(bus.op_a), 32'h11);
        check("t2_b", 32'(bus.op_b), 32'h22);
        step(1, 0, 8'h00, 0, 1);

        // Back-to-back load on the handshake cycle
        step(1, 1, 8'h01, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        step(1, 1, 8'h77, 0, 1);
        check("t3_a", 32'(bus.op_a), 32'h77);
        check("t3_valid", 32'(bus.op_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        step(1, 1, 8'h08, 0, 1);
        step(1, 0, 8'h00, 0, 1);

        // Partial load times out after T idle cycles
        step(1, 0, 8'h00, 1, 0);
        step(1, 1, 8'h3C, 0, 0);
        repeat (3) step(1, 0, 8'h00, 0, 0);
        check("t4_no_to_yet", 32'(timeout), 32'd0);
        step(1, 0, 8'h00, 0, 0);
        check("t4_to", 32'(timeout), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        step(1, 0, 8'h00, 0, 0);
        check("t4_to_fall", 32'(timeout), 32'd0);

        // ena low in GOT_A: strobes ignored, timer frozen
        step(1, 1, 8'hA0, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        repeat (3) step(0, 1, 8'hEE, 0, 1);
        step(1, 1, 8'hB0, 0, 0);
        check("t5_b", 32'(bus.op_b), 32'hB0);
        check("t5_valid", 32'(bus.op_valid), 32'd1);

        // Clear with strobe in ISSUE after an overrun
        step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h99, 1, 1);
        check("t6_clr_valid", 32'(bus.op_valid), 32'd0);
        check("t6_clr_ovr", 32'(overrun), 32'd0);

        // Async reset in GOT_A, no clock edge needed
        step(1, 1, 8'h5A, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("t6_rst_a", 32'(bus.op_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 1) == 0,
                 8'($urandom),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 4) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
